muldiv_seq: RTL and testbench

Multi-cycle sequencer for 16-bit unsigned multiply and divide. It replaces the single-cycle `*`, `/` and `%` ALU operations with a radix-2 iterative engine built on one 17-bit add/subtract path. The CPU datapath issues an operation with `start`, stalls while `busy` is high, and captures the `hi`/`lo` result when `done` pulses. The datapath's single-cycle ALU keeps add, sub, nor and slt.

---
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_muldiv_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle 16-bit unsigned multiply/divide sequencer.
// Radix-2 shift-add MUL and restoring DIV share a single 17-bit add/subtract path.
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic                 busy_r, done_r, busy_s, done_s;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   work_r, work_next_s;
    logic [WIDTH-1:0]     a_r, b_r, hi_r, lo_r;
    logic                 op_r, dbz_r;
    logic [WIDTH:0]       add_x_s, add_y_s, sum_s;
    logic                 add_cin_s;
    logic                 b_zero_s;

    assign b_zero_s = (b == {WIDTH{1'b0}});

    // State register plus registered status flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; a divide by zero skips RUN entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    if (op && b_zero_s) state_s = S_DONE;
                    else                state_s = S_RUN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_r == LAST_CNT) state_s = S_DONE;
                else                   state_s = S_RUN;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Status outputs for the upcoming state, captured by the state register.
    always_comb begin
        busy_s = (state_s != S_IDLE);
        done_s = (state_s == S_DONE);
    end

    // One iteration: MUL adds a when W[0] is set; DIV subtracts b via ~b + 1.
    always_comb begin
        add_x_s   = {(WIDTH+1){1'b0}};
        add_y_s   = {(WIDTH+1){1'b0}};
        add_cin_s = 1'b0;
        if (op_r == 1'b0) begin
            add_x_s = {1'b0, work_r[2*WIDTH-1:WIDTH]};
            add_y_s = work_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}};
        end else begin
            add_x_s   = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
            add_y_s   = ~{1'b0, b_r};
            add_cin_s = 1'b1;
        end
        sum_s = add_x_s + add_y_s + {{WIDTH{1'b0}}, add_cin_s};
        if (op_r == 1'b0) begin
            work_next_s = {sum_s, work_r[WIDTH-1:1]};
        end else if (!sum_s[WIDTH]) begin
            work_next_s = {sum_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b1};
        end else begin
            work_next_s = {work_r[2*WIDTH-2:WIDTH], work_r[WIDTH-1],
                           work_r[WIDTH-2:0], 1'b0};
        end
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            op_r   <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            work_r <= {(2*WIDTH){1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            dbz_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        op_r   <= op;
                        cnt_r  <= {CW{1'b0}};
                        work_r <= op ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
                        dbz_r  <= 1'b0;
                        if (op && b_zero_s) begin
                            hi_r  <= a;
                            lo_r  <= {WIDTH{1'b1}};
                            dbz_r <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        hi_r <= work_next_s[2*WIDTH-1:WIDTH];
                        lo_r <= work_next_s[WIDTH-1:0];
                    end
                end
                S_DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        busy, done, div_by_zero;
    logic [15:0] hi, lo;

    typedef struct {
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    muldiv_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", cyc, e.due);
                check("hi", {16'h0, hi}, {16'h0, e.hi});
                check("lo", {16'h0, lo}, {16'h0, e.lo});
                check("div_by_zero", {31'h0, div_by_zero}, {31'h0, e.dbz});
            end
        end
    end

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(nm, q.size(), 32'd0);
    endtask

    // Issue one op, scramble inputs afterwards, and check busy through the next IDLE.
    task automatic issue(input logic o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] eh, input logic [15:0] el, input logic ed);
        int   c, lat;
        exp_t e;
        @(negedge clk);
        c = cyc;
        start = 1'b1; op = o; a = x; b = y;
        lat = (o && (y == 16'h0000)) ? 1 : 17;
        e.hi = eh; e.lo = el; e.dbz = ed; e.due = c + lat;
        q.push_back(e);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0; op = ~o; a = ~x; b = 16'h0BAD;
            end
            check($sformatf("busy_c%0d", k), {31'h0, busy}, (k <= lat) ? 32'd1 : 32'd0);
        end
        check("drained", q.size(), 32'd0);
    endtask

    initial begin
        int c;
        exp_t e;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_hilo", {hi, lo}, 32'd0);
        check("rst_dbz", {31'h0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        issue(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0);
        issue(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        issue(1'b1, 16'd1000, 16'd7,    16'h0006, 16'h008E, 1'b0);
        issue(1'b1, 16'd5,    16'd9,    16'd5,    16'd0,    1'b0);
        issue(1'b1, 16'h00AB, 16'h0000, 16'h00AB, 16'hFFFF, 1'b1);
        issue(1'b0, 16'd3,    16'd4,    16'd0,    16'd12,   1'b0);
        issue(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0);
        issue(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);

        // start held high: operand change mid-run is ignored, re-accept only in cycle 18
        @(negedge clk);
        c = cyc;
        start = 1'b1; op = 1'b0; a = 16'd2; b = 16'd3;
        e.hi = 16'd0; e.lo = 16'd6; e.dbz = 1'b0; e.due = c + 17;
        q.push_back(e);
        repeat (5) @(negedge clk);
        a = 16'd9; b = 16'd9;
        repeat (12) @(negedge clk);
        check("hold_busy_c17", {31'h0, busy}, 32'd1);
        @(negedge clk);
        check("hold_busy_c18", {31'h0, busy}, 32'd0);
        e.hi = 16'd0; e.lo = 16'd81; e.dbz = 1'b0; e.due = c + 35;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("hold_busy_c19", {31'h0, busy}, 32'd1);
        wait_drain("hold_drain");

        // asynchronous reset in cycle 8 of a MUL
        @(negedge clk);
        c = cyc;
        start = 1'b1; op = 1'b0; a = 16'd5; b = 16'd5;
        e.hi = 16'd0; e.lo = 16'd25; e.dbz = 1'b0; e.due = c + 17;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", {31'h0, busy}, 32'd0);
        check("async_done", {31'h0, done}, 32'd0);
        check("async_hilo", {hi, lo}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 16'd7, 16'd8, 16'd0, 16'd56, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
